// File: rtl/nr_div_arbiter.sv
// nr_div_arbiter: round-robin front end that shares one iterative unsigned
// non-restoring divider among NREQ requesters. One request is accepted at a
// time. The result is held on a valid/ready response channel until the
// consumer takes it.
module nr_div_arbiter #(
    parameter int N    = 4,
    parameter int NREQ = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*N-1:0]          req_dd,
    input  logic [NREQ*N-1:0]          req_dr,
    output logic [NREQ-1:0]            req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [N-1:0]               quotient,
    output logic [N-1:0]               remainder,
    output logic                       div_by_zero,
    output logic                       busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int IW1 = IDW + 1;
    localparam int CW  = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t                state, state_nxt;
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        grant_id;
    logic [IDW-1:0]        next_ptr;
    logic [IW1-1:0]        scan_idx;
    logic                  found;
    logic [NREQ-1:0]       grant;
    logic                  transfer;
    logic [N-1:0]          gnt_dd, gnt_dr;
    logic [CW-1:0]         cnt;
    logic signed [N:0]     accu;
    logic signed [N:0]     accu_step;
    logic signed [N:0]     accu_fix;
    logic [N-1:0]          dd, dr;

    // One non-restoring step: shift {accu,dd} left, then subtract the divisor
    // when the old partial remainder was non-negative, add it otherwise.
    function automatic logic signed [N:0] nr_step(input logic signed [N:0] a,
                                                   input logic [N-1:0]      q,
                                                   input logic [N-1:0]      d);
        logic signed [N:0] sh;
        logic signed [N:0] dext;
        sh   = {a[N-1:0], q[N-1]};
        dext = $signed({1'b0, d});
        if (a[N])
            return sh + dext;
        else
            return sh - dext;
    endfunction

    // Remainder correction: a negative final partial remainder gets the
    // divisor added back once.
    function automatic logic signed [N:0] nr_fix(input logic signed [N:0] a,
                                                  input logic [N-1:0]      d);
        logic signed [N:0] dext;
        dext = $signed({1'b0, d});
        if (a[N])
            return a + dext;
        else
            return a;
    endfunction

    assign accu_step = nr_step(accu, dd, dr);
    assign accu_fix  = nr_fix(accu, dr);

    // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + IW1'(k);
            if (scan_idx >= IW1'(NREQ))
                scan_idx = scan_idx - IW1'(NREQ);
            if (!found && req_valid[scan_idx[IDW-1:0]]) begin
                found    = 1'b1;
                grant_id = scan_idx[IDW-1:0];
            end
        end
        if (found)
            grant[grant_id] = 1'b1;
    end

    // Operand select for the granted requester and the pointer that follows it.
    always_comb begin
        gnt_dd = '0;
        gnt_dr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                gnt_dd = req_dd[i*N +: N];
                gnt_dr = req_dr[i*N +: N];
            end
        end
        next_ptr = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end

    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign transfer  = |(req_valid & req_ready);
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (transfer) state_nxt = (gnt_dr == '0) ? DONE : ITER;
            ITER: if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration pointer, iteration counter and response owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            cnt    <= '0;
            rsp_id <= '0;
        end else if (state == IDLE && transfer) begin
            rr_ptr <= next_ptr;
            cnt    <= CW'(N);
            rsp_id <= grant_id;
        end else if (state == ITER) begin
            cnt    <= cnt - CW'(1);
        end
    end

    // Divider datapath and registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accu        <= '0;
            dd          <= '0;
            dr          <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        dd   <= gnt_dd;
                        dr   <= gnt_dr;
                        accu <= '0;
                        if (gnt_dr == '0) begin
                            quotient    <= '1;
                            remainder   <= gnt_dd;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    accu <= accu_step;
                    dd   <= {dd[N-2:0], ~accu_step[N]};
                end
                FIX: begin
                    accu        <= accu_fix;
                    quotient    <= dd;
                    remainder   <= accu_fix[N-1:0];
                    div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nr_div_arbiter.sv
// Bench for nr_div_arbiter: directed scenarios plus randomized traffic
// checked against an arithmetic and round-robin reference model.
module tb_nr_div_arbiter;

    localparam int N    = 4;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*N-1:0]    req_dd = '0;
    logic [NREQ*N-1:0]    req_dr = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [IDW-1:0]       rsp_id;
    logic [N-1:0]         quotient;
    logic [N-1:0]         remainder;
    logic                 div_by_zero;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    nr_div_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_dd(req_dd), .req_dr(req_dr),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
        req_dd[id*N +: N] = a;
        req_dr[id*N +: N] = b;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Present a request and return just after its accept edge.
    task automatic issue(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
        bit ok;
        ok = 0;
        set_op(id, a, b);
        req_valid[id] = 1'b1;
        #1;
        for (int k = 0; k < 40; k++) begin
            if (req_ready[id]) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL issue_timeout id=%0d req_ready=%b never granted", id, req_ready);
        end
        tick();
        req_valid[id] = 1'b0;
    endtask

    // Count edges (accept edge included) until rsp_valid is seen.
    task automatic wait_rsp(output int edges);
        edges = 1;
        while (!rsp_valid && edges < 60) begin
            tick();
            edges++;
        end
        if (!rsp_valid) begin
            total++; bad++;
            $display("FAIL rsp_timeout rsp_valid=%b after %0d edges", rsp_valid, edges);
        end
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        set_op(0, 4'd7, 4'd2);
        set_op(1, 4'd9, 4'd4);
        rst = 1'b1;
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if ({quotient, remainder, rsp_id, div_by_zero} !== '0) begin bad++;
            $display("FAIL reset_result got q=%0d r=%0d id=%0d dbz=%b want all 0", quotient, remainder, rsp_id, div_by_zero); end
        tick();
        rst = 1'b0;
        req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        int e;
        do_reset();
        rsp_ready = 1'b1;
        set_op(0, 4'd7, 4'd2);
        req_valid[0] = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_grant got=%b want=01", req_ready); end
        tick();
        req_valid[0] = 1'b0;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL single_grant_drop got=%b want=00", req_ready); end
        wait_rsp(e);
        total++; if (e != N + 2) begin bad++; $display("FAIL single_latency got=%0d edges want=%0d", e, N + 2); end
        total++; if (quotient !== 4'd3 || remainder !== 4'd1) begin bad++;
            $display("FAIL single_result got q=%0d r=%0d want q=3 r=1", quotient, remainder); end
        total++; if (rsp_id !== 1'b0 || div_by_zero !== 1'b0) begin bad++;
            $display("FAIL single_id got id=%0d dbz=%b want id=0 dbz=0", rsp_id, div_by_zero); end
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_clear got=%b want=0", rsp_valid); end
    endtask

    task automatic test_small_and_full();
        int e;
        logic [N-1:0] ta [3];
        logic [N-1:0] tb [3];
        int tid [3];
        ta = '{4'd3, 4'd15, 4'd15};
        tb = '{4'd5, 4'd1, 4'd15};
        tid = '{1, 0, 1};
        rsp_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            issue(tid[t], ta[t], tb[t]);
            wait_rsp(e);
            total++; if (quotient !== ta[t] / tb[t] || remainder !== ta[t] % tb[t]) begin bad++;
                $display("FAIL range_result %0d/%0d got q=%0d r=%0d want q=%0d r=%0d",
                         ta[t], tb[t], quotient, remainder, ta[t] / tb[t], ta[t] % tb[t]); end
            total++; if (rsp_id !== IDW'(tid[t])) begin bad++; $display("FAIL range_id got=%0d want=%0d", rsp_id, tid[t]); end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int gid[$], gcyc[$], rq[$], rr[$], ri[$];
        int ea [2];
        int eb [2];
        ea = '{7, 9};
        eb = '{2, 4};
        do_reset();
        rsp_ready = 1'b1;
        set_op(0, 4'd7, 4'd2);
        set_op(1, 4'd9, 4'd4);
        req_valid = 2'b11;
        #1;
        for (int c = 0; c < 32; c++) begin
            if (req_ready != 0) begin
                gid.push_back(req_ready[1] ? 1 : 0);
                gcyc.push_back(c);
            end
            if (rsp_valid) begin
                rq.push_back(int'(quotient)); rr.push_back(int'(remainder)); ri.push_back(int'(rsp_id));
            end
            tick();
        end
        req_valid = '0;
        total++; if (gid.size() < 4 || ri.size() < 4) begin bad++;
            $display("FAIL rr_count got grants=%0d results=%0d want >=4 each", gid.size(), ri.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                total++; if (gid[k] != k % 2) begin bad++; $display("FAIL rr_order k=%0d got=%0d want=%0d", k, gid[k], k % 2); end
                total++; if (ri[k] != k % 2 || rq[k] != ea[k % 2] / eb[k % 2] || rr[k] != ea[k % 2] % eb[k % 2]) begin bad++;
                    $display("FAIL rr_result k=%0d got q=%0d r=%0d id=%0d want q=%0d r=%0d id=%0d",
                             k, rq[k], rr[k], ri[k], ea[k % 2] / eb[k % 2], ea[k % 2] % eb[k % 2], k % 2); end
                if (k > 0) begin
                    total++; if (gcyc[k] - gcyc[k-1] != N + 3) begin bad++;
                        $display("FAIL rr_spacing k=%0d got=%0d want=%0d", k, gcyc[k] - gcyc[k-1], N + 3); end
                end
            end
        end
        do_reset();
    endtask

    task automatic test_div_zero();
        int e;
        rsp_ready = 1'b1;
        issue(0, 4'd9, 4'd0);
        wait_rsp(e);
        total++; if (e != 1) begin bad++; $display("FAIL dbz_latency got=%0d edges want=1", e); end
        total++; if (quotient !== 4'hF || remainder !== 4'd9 || div_by_zero !== 1'b1) begin bad++;
            $display("FAIL dbz_result got q=%0d r=%0d dbz=%b want q=15 r=9 dbz=1", quotient, remainder, div_by_zero); end
        tick();
        issue(1, 4'd6, 4'd4);
        wait_rsp(e);
        total++; if (div_by_zero !== 1'b0 || quotient !== 4'd1 || remainder !== 4'd2) begin bad++;
            $display("FAIL dbz_after got q=%0d r=%0d dbz=%b want q=1 r=2 dbz=0", quotient, remainder, div_by_zero); end
        tick();
    endtask

    task automatic test_backpressure();
        int e;
        do_reset();
        rsp_ready = 1'b0;
        issue(0, 4'd13, 4'd3);
        wait_rsp(e);
        set_op(1, 4'd5, 4'd5);
        req_valid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (rsp_valid !== 1'b1 || quotient !== 4'd4 || remainder !== 4'd1 || rsp_id !== 1'b0 || div_by_zero !== 1'b0) begin bad++;
                $display("FAIL bp_hold c=%0d got v=%b q=%0d r=%0d id=%0d want v=1 q=4 r=1 id=0", c, rsp_valid, quotient, remainder, rsp_id); end
            total++; if (req_ready !== 2'b00 || busy !== 1'b1) begin bad++;
                $display("FAIL bp_ctrl c=%0d got req_ready=%b busy=%b want 00 1", c, req_ready, busy); end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL bp_release got v=%b busy=%b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_reset_mid_iter();
        int e;
        do_reset();
        rsp_ready = 1'b1;
        issue(0, 4'd7, 4'd2);
        wait_rsp(e);
        tick();
        issue(1, 4'd11, 4'd3);
        tick();
        set_op(0, 4'd14, 4'd4);
        req_valid = 2'b11;
        rst = 1'b1;
        #1;
        total++; if ({rsp_valid, busy, req_ready, quotient, remainder, rsp_id, div_by_zero} !== '0) begin bad++;
            $display("FAIL midrst_outputs got v=%b busy=%b rdy=%b q=%0d r=%0d id=%0d dbz=%b want all 0",
                     rsp_valid, busy, req_ready, quotient, remainder, rsp_id, div_by_zero); end
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL midrst_grant got=%b want=01", req_ready); end
        tick();
        req_valid = '0;
        wait_rsp(e);
        total++; if (quotient !== 4'd3 || remainder !== 4'd2 || rsp_id !== 1'b0 || e != N + 2) begin bad++;
            $display("FAIL midrst_result got q=%0d r=%0d id=%0d edges=%0d want q=3 r=2 id=0 edges=%0d",
                     quotient, remainder, rsp_id, e, N + 2); end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] pa [NREQ];
        logic [N-1:0] pb [NREQ];
        bit pend [NREQ];
        int ptr, g, e, any, ea, eb, eq, er;
        bit edz;
        do_reset();
        ptr = 0;
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        for (int it = 0; it < 40; it++) begin
            any = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1 || (i == NREQ - 1 && any == 0))) begin
                    pend[i] = 1;
                    pa[i] = N'($urandom_range(0, 15));
                    pb[i] = ($urandom_range(0, 6) == 0) ? '0 : N'($urandom_range(1, 15));
                    set_op(i, pa[i], pb[i]);
                    req_valid[i] = 1'b1;
                end
                if (pend[i]) any = 1;
            end
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && pend[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
            #1;
            total++; if (req_ready !== (NREQ'(1) << g)) begin bad++;
                $display("FAIL rand_grant it=%0d got=%b want id %0d", it, req_ready, g); end
            tick();
            req_valid[g] = 1'b0;
            pend[g] = 0;
            ptr = (g + 1) % NREQ;
            ea = int'(pa[g]); eb = int'(pb[g]);
            edz = (eb == 0);
            eq = edz ? 15 : ea / eb;
            er = edz ? ea : ea % eb;
            rsp_ready = $urandom_range(0, 1) == 1;
            wait_rsp(e);
            total++; if (quotient !== N'(eq) || remainder !== N'(er) || div_by_zero !== edz || rsp_id !== IDW'(g)) begin bad++;
                $display("FAIL rand_result it=%0d %0d/%0d got q=%0d r=%0d dbz=%b id=%0d want q=%0d r=%0d dbz=%b id=%0d",
                         it, ea, eb, quotient, remainder, div_by_zero, rsp_id, eq, er, edz, g); end
            total++; if (e != (edz ? 1 : N + 2)) begin bad++;
                $display("FAIL rand_latency it=%0d got=%0d want=%0d", it, e, edz ? 1 : N + 2); end
            if (!rsp_ready) begin
                tick();
                tick();
                rsp_ready = 1'b1;
            end
            tick();
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand_idle it=%0d busy got=%b want=0", it, busy); end
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_small_and_full();
        test_round_robin();
        test_div_zero();
        test_backpressure();
        test_reset_mid_iter();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
